// File: rtl/prog_loader_pkg.sv
// Shared types for prog_loader: FSM states, frame header bytes and error codes.
// PROG_LOADER_CKSUM_EN adds the CKSUM state used for the per-frame checksum byte.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
`ifdef PROG_LOADER_CKSUM_EN
    S_CKSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] HDR_IMEM = 8'h49;
  localparam logic [7:0] HDR_DMEM = 8'h44;
  localparam logic [7:0] HDR_GO   = 8'h47;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_HDR   = 2'd1;
  localparam logic [1:0] ERR_COUNT = 2'd2;
  localparam logic [1:0] ERR_CKSUM = 2'd3;

endpackage

// File: rtl/prog_loader_byte_word_asm.sv
// Little-endian byte-to-word assembler: bytes shift in from the top, the word completes
// on its BYTES-th byte, when word_dat presents the full word combinationally with word_done.
module byte_word_asm #(
  parameter int BYTES = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 clr,
  input  logic                 byte_vld,
  input  logic [7:0]           byte_dat,
  output logic [8*BYTES-1:0]   word_dat,
  output logic                 word_done
);

  localparam int W = 8 * BYTES;

  logic [W-9:0] shreg;
  logic [2:0]   cnt;

  assign word_dat  = {byte_dat, shreg};
  assign word_done = byte_vld && (cnt == 3'(BYTES - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (byte_vld) begin
      shreg <= word_dat[W-1:8];
      cnt   <= word_done ? 3'd0 : cnt + 3'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader that writes imem/dmem and then releases the core.
// Optional PROG_LOADER_CKSUM_EN: each I/D frame ends with an XOR checksum of count+payload.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int IMEM_DEPTH = 128,
  parameter int DMEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  output logic        enable,
  output logic        busy,
  output logic [1:0]  err_code
);

  state_t      state;
  logic        sel_dmem;
  logic [7:0]  cnt_lo;
  logic [15:0] word_cnt;
  logic [15:0] word_idx;
  logic        acc;
  logic        in_data;
  logic        i_done;
  logic        d_done;
  logic        word_done;
  logic        last_word;
  logic        overflow;
  logic [15:0] count_in;
  logic [31:0] i_word;
  logic [63:0] d_word;

`ifdef PROG_LOADER_CKSUM_EN
  localparam state_t FRAME_END = S_CKSUM;
  logic [7:0] cksum;
`else
  localparam state_t FRAME_END = S_IDLE;
`endif

  assign s_ready   = (state != S_DONE);
  assign busy      = !(state inside {S_IDLE, S_DONE, S_ERR});
  assign ren_ext   = 1'b0;
  assign ren_ext_2 = 1'b0;
  assign acc       = s_valid && s_ready;
  assign in_data   = acc && (state == S_DATA);
  assign count_in  = {s_data, cnt_lo};
  assign overflow  = sel_dmem ? (int'(count_in) > DMEM_DEPTH) : (int'(count_in) > IMEM_DEPTH);
  assign word_done = sel_dmem ? d_done : i_done;
  assign last_word = (word_idx == word_cnt - 16'd1);

  byte_word_asm #(.BYTES(4)) u_imem_asm (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (state != S_DATA),
    .byte_vld  (in_data && !sel_dmem),
    .byte_dat  (s_data),
    .word_dat  (i_word),
    .word_done (i_done)
  );

  byte_word_asm #(.BYTES(8)) u_dmem_asm (
    .clk       (clk),
    .arst_n    (arst_n),
    .clr       (state != S_DATA),
    .byte_vld  (in_data && sel_dmem),
    .byte_dat  (s_data),
    .word_dat  (d_word),
    .word_done (d_done)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      sel_dmem    <= 1'b0;
      cnt_lo      <= '0;
      word_cnt    <= '0;
      word_idx    <= '0;
      addr_ext    <= '0;
      wen_ext     <= 1'b0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wen_ext_2   <= 1'b0;
      wdata_ext_2 <= '0;
      enable      <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      // Write port outputs are single-cycle pulses and read as zero otherwise.
      wen_ext     <= 1'b0;
      wen_ext_2   <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      addr_ext_2  <= '0;
      wdata_ext_2 <= '0;
      if (acc) begin
        case (state)
          S_IDLE: begin
            if (s_data == HDR_IMEM || s_data == HDR_DMEM) begin
              sel_dmem <= (s_data == HDR_DMEM);
              state    <= S_CNT_LO;
            end else if (s_data == HDR_GO) begin
              enable <= 1'b1;
              state  <= S_DONE;
            end else begin
              err_code <= ERR_HDR;
              state    <= S_ERR;
            end
          end
          S_CNT_LO: begin
            cnt_lo <= s_data;
            state  <= S_CNT_HI;
          end
          S_CNT_HI: begin
            word_cnt <= count_in;
            word_idx <= '0;
            if (overflow) begin
              err_code <= ERR_COUNT;
              state    <= S_ERR;
            end else if (count_in == 16'd0) begin
              state <= FRAME_END;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            if (word_done) begin
              if (sel_dmem) begin
                wen_ext_2   <= 1'b1;
                addr_ext_2  <= {45'd0, word_idx, 3'd0};
                wdata_ext_2 <= d_word;
              end else begin
                wen_ext   <= 1'b1;
                addr_ext  <= {46'd0, word_idx, 2'd0};
                wdata_ext <= i_word;
              end
              word_idx <= word_idx + 16'd1;
              if (last_word) state <= FRAME_END;
            end
          end
`ifdef PROG_LOADER_CKSUM_EN
          S_CKSUM: begin
            if (s_data == cksum) begin
              state <= S_IDLE;
            end else begin
              err_code <= ERR_CKSUM;
              state    <= S_ERR;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifdef PROG_LOADER_CKSUM_EN
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cksum <= '0;
    end else if (acc) begin
      case (state)
        S_CNT_LO:         cksum <= s_data;
        S_CNT_HI, S_DATA: cksum <= cksum ^ s_data;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed vector table, hand-written corner sequences,
// and randomized frame streams checked against a frame-parsing reference model.
module tb_prog_loader;

  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic        enable;
  logic        busy;
  logic [1:0]  err_code;

  prog_loader #(.IMEM_DEPTH(DEPTH), .DMEM_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .enable      (enable),
    .busy        (busy),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic        mem;
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;
  typedef struct {
    logic [23:0][7:0] b;
    int               len;
    logic [1:0]       err;
    logic             en;
    int               nw;
    wr_t [1:0]        w;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  wr_t  wlog[$];
  wr_t  exp_w[$];
  vec_t vecs[8];
  int   nvec = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic wr_t mk(input logic mem, input logic [63:0] addr, input logic [63:0] data);
    wr_t w;
    w.mem = mem; w.addr = addr; w.data = data;
    return w;
  endfunction

  // Observe every write pulse; a pulse wider than one cycle shows up as a duplicate entry.
  always @(negedge clk) begin
    if (arst_n) begin
      if (wen_ext)   wlog.push_back(mk(1'b0, addr_ext, {32'd0, wdata_ext}));
      if (wen_ext_2) wlog.push_back(mk(1'b1, addr_ext_2, wdata_ext_2));
      chk("wen_exclusive", {63'd0, wen_ext & wen_ext_2}, 64'd0);
      chk("ren_tied_low", {62'd0, ren_ext, ren_ext_2}, 64'd0);
      if (!wen_ext)   chk("imem_idle_zero", addr_ext | {32'd0, wdata_ext}, 64'd0);
      if (!wen_ext_2) chk("dmem_idle_zero", addr_ext_2 | wdata_ext_2, 64'd0);
    end
  end

  function automatic bq_t with_ck(input bq_t f);
    bq_t r;
`ifdef PROG_LOADER_CKSUM_EN
    logic [7:0] x;
`endif
    r = f;
`ifdef PROG_LOADER_CKSUM_EN
    x = 8'h00;
    for (int i = 1; i < f.size(); i++) x ^= f[i];
    r.push_back(x);
`endif
    return r;
  endfunction

  task automatic drive(input logic [7:0] b, output bit acc);
    s_valid = 1'b1;
    s_data  = b;
    acc     = s_ready;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_q(input bq_t q, input bit gaps);
    bit a;
    for (int i = 0; i < q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      drive(q[i], a);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, {63'd0, s_ready}, 64'd1);
    chk({tag, "_enable"},  {63'd0, enable}, 64'd0);
    chk({tag, "_busy"},    {63'd0, busy}, 64'd0);
    chk({tag, "_err"},     {62'd0, err_code}, 64'd0);
    chk({tag, "_wen"},     {62'd0, wen_ext, wen_ext_2}, 64'd0);
    chk({tag, "_ports"},   addr_ext | addr_ext_2 | wdata_ext_2 | {32'd0, wdata_ext}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n  = 1'b0;
    s_valid = 1'b0;
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    arst_n = 1'b1;
    wlog.delete();
  endtask

  task automatic cmp_writes(input string tag, input wr_t e[$]);
    chk({tag, "_nwrites"}, 64'(wlog.size()), 64'(e.size()));
    for (int i = 0; i < wlog.size() && i < e.size(); i++) begin
      chk($sformatf("%s_w%0d_mem", tag, i),  {63'd0, wlog[i].mem}, {63'd0, e[i].mem});
      chk($sformatf("%s_w%0d_addr", tag, i), wlog[i].addr, e[i].addr);
      chk($sformatf("%s_w%0d_data", tag, i), wlog[i].data, e[i].data);
    end
  endtask

  task automatic add_vec(input bq_t s, input logic [1:0] err, input logic en, input int nw,
                         input wr_t w0, input wr_t w1);
    vecs[nvec].len = s.size();
    for (int i = 0; i < s.size(); i++) vecs[nvec].b[i] = s[i];
    vecs[nvec].err  = err;
    vecs[nvec].en   = en;
    vecs[nvec].nw   = nw;
    vecs[nvec].w[0] = w0;
    vecs[nvec].w[1] = w1;
    nvec++;
  endtask

  // Reference model: walks whole frames of the stream and lists the memory writes they imply.
  task automatic model(input bq_t q, output logic [1:0] err, output logic en);
    int i;
    int n;
    int bpw;
    logic dm;
    logic [7:0] ck;
    logic [63:0] w;
    exp_w.delete();
    err = 2'd0;
    en  = 1'b0;
    i   = 0;
    while (i < q.size()) begin
      if (q[i] == 8'h47) begin en = 1'b1; break; end
      if (q[i] != 8'h49 && q[i] != 8'h44) begin err = 2'd1; break; end
      dm  = (q[i] == 8'h44);
      bpw = dm ? 8 : 4;
      n   = int'(q[i+1]) + 256 * int'(q[i+2]);
      ck  = q[i+1] ^ q[i+2];
      i  += 3;
      if (n > DEPTH) begin err = 2'd2; break; end
      for (int k = 0; k < n; k++) begin
        w = 64'd0;
        for (int b = 0; b < bpw; b++) begin
          w  = w | (64'(q[i]) << (8 * b));
          ck = ck ^ q[i];
          i++;
        end
        exp_w.push_back(mk(dm, 64'(k * bpw), w));
      end
`ifdef PROG_LOADER_CKSUM_EN
      if (q[i] != ck) begin err = 2'd3; break; end
      i++;
`endif
    end
  endtask

  task automatic gen_stream(input int it, output bq_t q);
    int nf;
    int r;
    int n;
    logic dm;
    logic [7:0] b;
    logic [7:0] ck;
    q.delete();
    nf = $urandom_range(1, 3);
    for (int f = 0; f < nf; f++) begin
      r = (f == 0 && it < 2) ? 5 : $urandom_range(0, 11);
      if (r == 0) begin
        do b = 8'($urandom); while (b == 8'h49 || b == 8'h44 || b == 8'h47);
        q.push_back(b);
      end else begin
        dm = (f == 0 && it < 2) ? (it == 1) : 1'($urandom_range(0, 1));
        q.push_back(dm ? 8'h44 : 8'h49);
        if (r == 1) n = DEPTH + $urandom_range(1, 300);
        else if (f == 0 && it < 2) n = DEPTH;
        else n = $urandom_range(0, 5);
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        ck = 8'(n) ^ 8'(n >> 8);
        if (r != 1) begin
          for (int k = 0; k < n * (dm ? 8 : 4); k++) begin
            b = 8'($urandom);
            ck ^= b;
            q.push_back(b);
          end
`ifdef PROG_LOADER_CKSUM_EN
          if ($urandom_range(0, 7) == 0) ck ^= 8'h5A;
          q.push_back(ck);
`endif
        end
      end
    end
    if ($urandom_range(0, 1) == 1) begin
      q.push_back(8'h47);
      q.push_back(8'($urandom));
    end
  endtask

  initial begin
    bq_t  q;
    bq_t  q2;
    wr_t  e[$];
    wr_t  z;
    bit   a;
    logic [1:0] m_err;
    logic m_en;

    z = mk(1'b0, 64'd0, 64'd0);

    q = '{8'h49, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    add_vec(with_ck(q), 2'd0, 1'b0, 2, mk(1'b0, 64'h0, 64'h13), mk(1'b0, 64'h4, 64'h00100093));
    q = '{8'h44, 8'h01, 8'h00, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00};
    add_vec(with_ck(q), 2'd0, 1'b0, 1, mk(1'b1, 64'h0, 64'h000000123456789A), z);
    q = '{8'h47};
    add_vec(q, 2'd0, 1'b1, 0, z, z);
    q = '{8'h55, 8'h47};
    add_vec(q, 2'd1, 1'b0, 0, z, z);
    q = '{8'h49, 8'h81, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    add_vec(q, 2'd2, 1'b0, 0, z, z);
    q = '{8'h44, 8'h81, 8'h00};
    add_vec(q, 2'd2, 1'b0, 0, z, z);
    q = '{8'h49, 8'h00, 8'h00};
    q = with_ck(q);
    q.push_back(8'h47);
    add_vec(q, 2'd0, 1'b1, 0, z, z);
    q  = '{8'h49, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    q2 = '{8'h44, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    q  = with_ck(q);
    q2 = with_ck(q2);
    for (int i = 0; i < q2.size(); i++) q.push_back(q2[i]);
    add_vec(q, 2'd0, 1'b0, 2, mk(1'b0, 64'h0, 64'hDEADBEEF), mk(1'b1, 64'h0, 64'h0807060504030201));

    for (int v = 0; v < nvec; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].len; i++) drive(vecs[v].b[i], a);
      idle(3);
      chk($sformatf("vec%0d_err", v), {62'd0, err_code}, {62'd0, vecs[v].err});
      chk($sformatf("vec%0d_enable", v), {63'd0, enable}, {63'd0, vecs[v].en});
      chk($sformatf("vec%0d_busy", v), {63'd0, busy}, 64'd0);
      e.delete();
      for (int i = 0; i < vecs[v].nw; i++) e.push_back(vecs[v].w[i]);
      cmp_writes($sformatf("vec%0d", v), e);
    end

    // Go: enable one cycle after the handshake, then no further bytes are taken.
    do_reset();
    chk("go_enable_before", {63'd0, enable}, 64'd0);
    drive(8'h47, a);
    chk("go_accepted", {63'd0, a}, 64'd1);
    chk("go_enable_after", {63'd0, enable}, 64'd1);
    chk("go_s_ready", {63'd0, s_ready}, 64'd0);
    drive(8'h49, a);
    chk("go_next_not_accepted", {63'd0, a}, 64'd0);

    // Write pulse lands the cycle after the final byte, overlapping the next header byte.
    do_reset();
    q = '{8'h49, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    q = with_ck(q);
    for (int i = 0; i < 7; i++) begin
      drive(q[i], a);
      if (i < 6) chk($sformatf("lat_no_early_wen_%0d", i), {63'd0, wen_ext}, 64'd0);
    end
    chk("lat_wen", {63'd0, wen_ext}, 64'd1);
    chk("lat_addr", addr_ext, 64'h0);
    chk("lat_data", {32'd0, wdata_ext}, 64'h44332211);
    idle(1);
    chk("lat_wen_width", {63'd0, wen_ext}, 64'd0);
`ifdef PROG_LOADER_CKSUM_EN
    drive(q[7], a);
    chk("lat_cksum_ok", {62'd0, err_code}, 64'd0);
`endif

    // Reset mid-frame drops the partial word; a fresh frame loads normally afterwards.
    do_reset();
    q = '{8'h49, 8'h01, 8'h00, 8'hAA, 8'hBB};
    for (int i = 0; i < q.size(); i++) drive(q[i], a);
    chk("midrst_busy_before", {63'd0, busy}, 64'd1);
    arst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    arst_n = 1'b1;
    idle(2);
    chk("midrst_no_write", 64'(wlog.size()), 64'd0);
    q = '{8'h49, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_q(with_ck(q), 1'b0);
    idle(3);
    e.delete();
    e.push_back(mk(1'b0, 64'h0, 64'h44332211));
    cmp_writes("midrst_reload", e);

`ifdef PROG_LOADER_CKSUM_EN
    do_reset();
    q = '{8'h49, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h47};
    send_q(q, 1'b0);
    idle(3);
    chk("ckbad_err", {62'd0, err_code}, 64'd3);
    chk("ckbad_enable", {63'd0, enable}, 64'd0);
    e.delete();
    e.push_back(mk(1'b0, 64'h0, 64'h04030201));
    cmp_writes("ckbad", e);
`endif

    for (int it = 0; it < 25; it++) begin
      do_reset();
      gen_stream(it, q);
      model(q, m_err, m_en);
      send_q(q, 1'b1);
      idle(3);
      chk($sformatf("rnd%0d_err", it), {62'd0, err_code}, {62'd0, m_err});
      chk($sformatf("rnd%0d_enable", it), {63'd0, enable}, {63'd0, m_en});
      chk($sformatf("rnd%0d_s_ready", it), {63'd0, s_ready}, {63'd0, !m_en});
      cmp_writes($sformatf("rnd%0d", it), exp_w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
